// File: rtl/router_pkg.sv
// Shared constants, helpers and types for the router output buffers.
package router_pkg;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LEN_MSB = 7;
    localparam int DEF_LEN_LSB = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                  tag;
        logic [DEF_DATA_W-1:0] data;
    } tagged_word_t;
endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake bundle between the router FSM side and a packet FIFO.
interface router_pkt_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    import router_pkg::*;
    localparam int LVL_W = clog2(DEPTH) + 1;

    logic              write_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              pkt_last;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [LVL_W-1:0]  level;

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, data_valid, pkt_last, full, empty, almost_full, level
    );
    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, data_valid, pkt_last, full, empty, almost_full, level
    );
endinterface

// File: rtl/router_fifo_ctrl.sv
// Wrap-bit pointer pair with occupancy and full/empty/almost-full status.
module router_fifo_ctrl
    import router_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 14,
    localparam int AW = clog2(DEPTH),
    localparam int PW = AW + 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clear,
    input  logic          wr_req,
    input  logic          rd_req,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic [AW-1:0] wr_idx,
    output logic [AW-1:0] rd_idx,
    output logic [PW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          almost_full
);
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // Pointer difference is the occupancy; the wrap bit makes 0 and DEPTH distinct.
    assign level       = wr_ptr - rd_ptr;
    assign almost_full = (level >= PW'(AFULL_LVL));
    assign wr_acc      = wr_req && !full;
    assign rd_acc      = rd_req && !empty;
    assign wr_idx      = wr_ptr[AW-1:0];
    assign rd_idx      = rd_ptr[AW-1:0];

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
        end
    end
endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO: header-tagged storage, registered read data and
// a parity-byte marker derived from the header length field.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = 16,
    parameter int LEN_MSB   = DEF_LEN_MSB,
    parameter int LEN_LSB   = DEF_LEN_LSB,
    parameter int AFULL_LVL = 14,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = LEN_MSB - LEN_LSB + 1,
    localparam int REM_W = LW + 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic soft_reset,
    router_pkt_fifo_if.slave bus
);
    typedef struct packed {
        logic              tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              wr_acc;
    logic              rd_acc;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              lfd_q;
    logic [DEPTH-1:0]  tag_mem;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [REM_W-1:0]  rem;
    entry_t            rd_word;
    logic [LW-1:0]     hdr_len;

    router_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) u_ctrl (
        .clock       (clock),
        .resetn      (resetn),
        .clear       (soft_reset),
        .wr_req      (bus.write_enb),
        .rd_req      (bus.read_enb),
        .wr_acc      (wr_acc),
        .rd_acc      (rd_acc),
        .wr_idx      (wr_idx),
        .rd_idx      (rd_idx),
        .level       (bus.level),
        .full        (bus.full),
        .empty       (bus.empty),
        .almost_full (bus.almost_full)
    );

    assign rd_word = '{tag: tag_mem[rd_idx], data: data_mem[rd_idx]};
    assign hdr_len = rd_word.data[LEN_MSB:LEN_LSB];

    // Payload storage is not reset; only the tags must be clean after a flush.
    always_ff @(posedge clock) begin
        if (resetn && !soft_reset && wr_acc) data_mem[wr_idx] <= bus.data_in;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            lfd_q          <= 1'b0;
            tag_mem        <= '0;
            rem            <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.pkt_last   <= 1'b0;
        end else if (soft_reset) begin
            lfd_q          <= 1'b0;
            tag_mem        <= '0;
            rem            <= '0;
            bus.data_valid <= 1'b0;
            bus.pkt_last   <= 1'b0;
        end else begin
            lfd_q          <= bus.lfd_state;
            bus.data_valid <= rd_acc;
            bus.pkt_last   <= 1'b0;
            if (wr_acc) tag_mem[wr_idx] <= lfd_q;
            if (rd_acc) begin
                bus.data_out <= rd_word.data;
                // A header always reloads, abandoning any unfinished packet.
                if (rd_word.tag) begin
                    rem <= REM_W'(hdr_len) + REM_W'(1);
                end else if (rem != '0) begin
                    rem          <= rem - REM_W'(1);
                    bus.pkt_last <= (rem == REM_W'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo using a queue-based packet model.
module tb_router_pkt_fifo;
    import router_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic soft_reset = 1'b0;
    always #5 clock = ~clock;

    router_pkt_fifo_if #(.DATA_W(8),  .DEPTH(16)) bus  ();
    router_pkt_fifo_if #(.DATA_W(16), .DEPTH(64)) bus6 ();

    router_pkt_fifo u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    router_pkt_fifo #(.DATA_W(16), .DEPTH(64), .AFULL_LVL(60)) u_dut6 (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus6)
    );

    typedef struct {
        logic [7:0] data;
        bit         last;
    } mword_t;

    mword_t     q[$];
    int         wrem = 0;
    bit         lfd_prev = 1'b0;
    logic [7:0] exp_dout = 8'h00;
    bit         exp_valid = 1'b0;
    bit         exp_last = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // One clock of stimulus on the default DUT; the model decides acceptance from
    // its own occupancy and marks the parity byte when a packet is written.
    task automatic step(input bit we, input bit lfd, input logic [7:0] din, input bit re);
        bit     wok, rok;
        mword_t w;
        bus.write_enb = we; bus.lfd_state = lfd; bus.data_in = din; bus.read_enb = re;
        wok = we && (q.size() < 16);
        rok = re && (q.size() > 0);
        exp_valid = rok;
        exp_last  = 1'b0;
        if (rok) begin
            w = q.pop_front();
            exp_dout = w.data;
            exp_last = w.last;
        end
        if (wok) begin
            w.data = din;
            w.last = 1'b0;
            if (lfd_prev) begin
                wrem = int'(din[7:2]) + 1;
            end else if (wrem > 0) begin
                wrem--;
                w.last = (wrem == 0);
            end
            q.push_back(w);
        end
        lfd_prev = lfd;
        @(posedge clock); #1;
        bus.write_enb = 1'b0; bus.lfd_state = 1'b0; bus.read_enb = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.data_out); end
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.data_valid); end
        checks++; if (bus.pkt_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.pkt_last); end
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin failures++; $display("FAIL reset_flags got e=%b f=%b af=%b exp e=1 f=0 af=0", bus.empty, bus.full, bus.almost_full); end
        checks++; if (bus6.level !== 7'd0 || bus6.empty !== 1'b1) begin failures++; $display("FAIL reset_wide got lvl=%0d e=%b exp lvl=0 e=1", bus6.level, bus6.empty); end
        resetn = 1'b1;
        q.delete(); wrem = 0; lfd_prev = 1'b0; exp_dout = 8'h00; exp_valid = 1'b0; exp_last = 1'b0;
    endtask

    task automatic test_packet();
        logic [7:0] seq [5];
        seq = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h5A};
        step(0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, seq[i], 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 1);
            checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL pkt_valid[%0d] got=%b exp=1", i, bus.data_valid); end
            checks++; if (bus.data_out !== seq[i]) begin failures++; $display("FAIL pkt_dout[%0d] got=%h exp=%h", i, bus.data_out, seq[i]); end
            checks++; if (bus.pkt_last !== (i == 4)) begin failures++; $display("FAIL pkt_last[%0d] got=%b exp=%b", i, bus.pkt_last, (i == 4)); end
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL pkt_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 17; i++) begin
            step(1, 0, 8'($urandom), 0);
            checks++; if (bus.level !== 5'(q.size())) begin failures++; $display("FAIL full_level[%0d] got=%0d exp=%0d", i, bus.level, q.size()); end
            checks++; if (bus.almost_full !== (q.size() >= 14)) begin failures++; $display("FAIL full_afull[%0d] got=%b exp=%b", i, bus.almost_full, (q.size() >= 14)); end
            checks++; if (bus.full !== (q.size() == 16)) begin failures++; $display("FAIL full_full[%0d] got=%b exp=%b", i, bus.full, (q.size() == 16)); end
        end
        checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL full_drop got=%0d exp=16", bus.level); end
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 8'h00, 1);
            checks++; if (bus.data_valid !== exp_valid || bus.data_valid !== (i < 16)) begin failures++; $display("FAIL drain_valid[%0d] got=%b exp=%b", i, bus.data_valid, (i < 16)); end
            checks++; if (bus.data_out !== exp_dout) begin failures++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, bus.data_out, exp_dout); end
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) step(1, 0, 8'($urandom), 0);
        step(1, 0, 8'hEE, 1);
        checks++; if (bus.level !== 5'd15) begin failures++; $display("FAIL simul_full_level got=%0d exp=15", bus.level); end
        checks++; if (bus.data_out !== exp_dout) begin failures++; $display("FAIL simul_full_dout got=%h exp=%h", bus.data_out, exp_dout); end
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1);
        step(1, 0, 8'($urandom), 1);
        checks++; if (bus.level !== 5'd5) begin failures++; $display("FAIL simul_mid_level got=%0d exp=5", bus.level); end
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom), 0, 8'($urandom), 1'($urandom));
            checks++; if (bus.level !== 5'(q.size())) begin failures++; $display("FAIL mixed_level[%0d] got=%0d exp=%0d", i, bus.level, q.size()); end
            checks++; if (bus.data_valid !== exp_valid || bus.data_out !== exp_dout) begin failures++; $display("FAIL mixed_read[%0d] got v=%b d=%h exp v=%b d=%h", i, bus.data_valid, bus.data_out, exp_valid, exp_dout); end
        end
        for (int i = 0; i < 16 && q.size() > 0; i++) begin
            step(0, 0, 8'h00, 1);
            checks++; if (bus.data_out !== exp_dout || bus.pkt_last !== exp_last) begin failures++; $display("FAIL mixed_drain[%0d] got d=%h l=%b exp d=%h l=%b", i, bus.data_out, bus.pkt_last, exp_dout, exp_last); end
        end
    endtask

    task automatic test_soft_reset();
        logic [7:0] held;
        step(0, 1, 8'h00, 0);
        step(1, 0, 8'h18, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
        held = exp_dout;
        bus.read_enb = 1'b1; bus.write_enb = 1'b1; bus.data_in = 8'hEE; soft_reset = 1'b1;
        @(posedge clock); #1;
        soft_reset = 1'b0; bus.read_enb = 1'b0; bus.write_enb = 1'b0;
        q.delete(); wrem = 0; lfd_prev = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
        checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL soft_flags got lvl=%0d e=%b exp lvl=0 e=1", bus.level, bus.empty); end
        checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL soft_valid got=%b exp=0", bus.data_valid); end
        checks++; if (bus.data_out !== held) begin failures++; $display("FAIL soft_hold got=%h exp=%h", bus.data_out, held); end
        step(0, 1, 8'h00, 0);
        step(1, 0, 8'h04, 0);
        step(1, 0, 8'h77, 0);
        step(1, 0, 8'h3C, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'h00, 1);
            checks++; if (bus.data_out !== exp_dout || bus.pkt_last !== (i == 2)) begin failures++; $display("FAIL soft_pkt[%0d] got d=%h l=%b exp d=%h l=%b", i, bus.data_out, bus.pkt_last, exp_dout, (i == 2)); end
        end
    endtask

    task automatic test_len0();
        step(0, 1, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'hA5, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 8'h00, 1);
            checks++; if (bus.data_valid !== 1'b1 || bus.pkt_last !== (i == 1)) begin failures++; $display("FAIL len0[%0d] got v=%b l=%b exp v=1 l=%b", i, bus.data_valid, bus.pkt_last, (i == 1)); end
        end
        checks++; if (bus.data_out !== 8'hA5 || bus.empty !== 1'b1) begin failures++; $display("FAIL len0_end got d=%h e=%b exp d=a5 e=1", bus.data_out, bus.empty); end
    endtask

    task automatic test_random_pkts();
        int len;
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(0, 5);
            step(0, 1, 8'h00, 0);
            step(1, 0, {6'(len), 2'($urandom)}, 0);
            for (int i = 0; i <= len; i++) step(1, 0, 8'($urandom), 0);
            for (int i = 0; i < len + 2; i++) begin
                step(0, 0, 8'h00, 1);
                checks++; if (bus.data_out !== exp_dout || bus.data_valid !== 1'b1) begin failures++; $display("FAIL rpkt_data[%0d.%0d] got d=%h v=%b exp d=%h v=1", p, i, bus.data_out, bus.data_valid, exp_dout); end
                checks++; if (bus.pkt_last !== (i == len + 1)) begin failures++; $display("FAIL rpkt_last[%0d.%0d] got=%b exp=%b", p, i, bus.pkt_last, (i == len + 1)); end
            end
        end
    endtask

    task automatic test_wide();
        logic [15:0] seq [5];
        logic [15:0] fill [64];
        seq = '{16'hAB0C, 16'h0011, 16'h0022, 16'h0033, 16'h005A};
        bus6.lfd_state = 1'b1; @(posedge clock); #1; bus6.lfd_state = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus6.write_enb = 1'b1; bus6.data_in = seq[i]; @(posedge clock); #1;
        end
        bus6.write_enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus6.read_enb = 1'b1; @(posedge clock); #1;
            checks++; if (bus6.data_valid !== 1'b1 || bus6.data_out !== seq[i] || bus6.pkt_last !== (i == 4)) begin failures++; $display("FAIL wide_pkt[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, bus6.data_valid, bus6.data_out, bus6.pkt_last, seq[i], (i == 4)); end
        end
        bus6.read_enb = 1'b0;
        for (int i = 0; i < 65; i++) begin
            if (i < 64) fill[i] = 16'($urandom);
            bus6.write_enb = 1'b1; bus6.data_in = (i < 64) ? fill[i] : 16'hDEAD; @(posedge clock); #1;
            checks++; if (bus6.level !== 7'((i < 64) ? i + 1 : 64)) begin failures++; $display("FAIL wide_level[%0d] got=%0d exp=%0d", i, bus6.level, (i < 64) ? i + 1 : 64); end
            checks++; if (bus6.almost_full !== (i >= 59) || bus6.full !== (i >= 63)) begin failures++; $display("FAIL wide_flags[%0d] got af=%b f=%b exp af=%b f=%b", i, bus6.almost_full, bus6.full, (i >= 59), (i >= 63)); end
        end
        bus6.write_enb = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus6.read_enb = 1'b1; @(posedge clock); #1;
            checks++; if (bus6.data_out !== fill[i] || bus6.pkt_last !== 1'b0) begin failures++; $display("FAIL wide_drain[%0d] got d=%h l=%b exp d=%h l=0", i, bus6.data_out, bus6.pkt_last, fill[i]); end
        end
        bus6.read_enb = 1'b0;
        checks++; if (bus6.empty !== 1'b1) begin failures++; $display("FAIL wide_empty got=%b exp=1", bus6.empty); end
    endtask

    initial begin
        bus.write_enb = 1'b0; bus.lfd_state = 1'b0; bus.data_in = 8'h00; bus.read_enb = 1'b0;
        bus6.write_enb = 1'b0; bus6.lfd_state = 1'b0; bus6.data_in = 16'h0000; bus6.read_enb = 1'b0;
        test_reset();
        test_packet();
        test_full();
        test_simultaneous();
        test_soft_reset();
        test_len0();
        test_random_pkts();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
